// File: rtl/synapse_update_sequencer_if.sv
// Control bundle between the top-level controller, the update sequencer and synaptic_core.
//   master : sequencer side (takes start/is_train, drives SRAM strobes, addresses, status)
//   slave  : controller/core side (drives start/is_train, observes everything else)
// Signals:
//   start_update, is_train                       controller -> sequencer
//   ctrl_synarray_cs/we, ctrl_synarray_addr      synaptic SRAM strobes and word address
//   ctrl_grad_array_cs/we                        gradient SRAM strobes (mirror synaptic strobes)
//   ctrl_pre_neuron_addr, ctrl_post_neuron_word_addr  neuron indices of the current word
//   ctrl_tref_event                              update-enable strobe, high in WRITE only
//   update_busy, update_done                     sweep status
interface synapse_update_sequencer_if #(
  parameter int unsigned SYN_ARRAY_ADDR_WIDTH      = 16,
  parameter int unsigned PRE_NEUR_ADDR_WIDTH       = 10,
  parameter int unsigned POST_NEUR_WORD_ADDR_WIDTH = 8
) ();

  logic                                 start_update;
  logic                                 is_train;
  logic                                 ctrl_synarray_cs;
  logic                                 ctrl_synarray_we;
  logic [SYN_ARRAY_ADDR_WIDTH-1:0]      ctrl_synarray_addr;
  logic                                 ctrl_grad_array_cs;
  logic                                 ctrl_grad_array_we;
  logic [PRE_NEUR_ADDR_WIDTH-1:0]       ctrl_pre_neuron_addr;
  logic [POST_NEUR_WORD_ADDR_WIDTH-1:0] ctrl_post_neuron_word_addr;
  logic                                 ctrl_tref_event;
  logic                                 update_busy;
  logic                                 update_done;

  modport master (
    input  start_update,
    input  is_train,
    output ctrl_synarray_cs,
    output ctrl_synarray_we,
    output ctrl_synarray_addr,
    output ctrl_grad_array_cs,
    output ctrl_grad_array_we,
    output ctrl_pre_neuron_addr,
    output ctrl_post_neuron_word_addr,
    output ctrl_tref_event,
    output update_busy,
    output update_done
  );

  modport slave (
    output start_update,
    output is_train,
    input  ctrl_synarray_cs,
    input  ctrl_synarray_we,
    input  ctrl_synarray_addr,
    input  ctrl_grad_array_cs,
    input  ctrl_grad_array_we,
    input  ctrl_pre_neuron_addr,
    input  ctrl_post_neuron_word_addr,
    input  ctrl_tref_event,
    input  update_busy,
    input  update_done
  );

endinterface

// File: rtl/synapse_update_sequencer.sv
// Drives the synaptic/gradient SRAM control during the FF-STDP weight update. On an accepted start it
// sweeps every synaptic word once (pre-major, post-word-minor), giving each word a READ / WAIT / WRITE
// cycle while presenting that word's pre/post neuron indices. Owns addresses and strobes only.
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : synchronous active-high reset
//   bus  : synapse_update_sequencer_if.master (start/is_train in; strobes, addresses, status out)
module synapse_update_sequencer #(
  parameter int unsigned INPUT_NEURON              = 784,
  parameter int unsigned OUTPUT_NEURON             = 256,
  parameter int unsigned POST_NEUR_PARALLEL        = 4,
  parameter int unsigned SYN_ARRAY_ADDR_WIDTH      = 16,
  parameter int unsigned PRE_NEUR_ADDR_WIDTH       = 10,
  parameter int unsigned POST_NEUR_WORD_ADDR_WIDTH = 8
) (
  input logic                          clk,
  input logic                          rst,
  synapse_update_sequencer_if.master   bus
);

  localparam int unsigned POST_WORDS = OUTPUT_NEURON / POST_NEUR_PARALLEL;

  localparam logic [PRE_NEUR_ADDR_WIDTH-1:0] LastPre =
      PRE_NEUR_ADDR_WIDTH'(INPUT_NEURON - 1);
  localparam logic [POST_NEUR_WORD_ADDR_WIDTH-1:0] LastPost =
      POST_NEUR_WORD_ADDR_WIDTH'(POST_WORDS - 1);

  typedef enum logic [2:0] {StIdle, StRead, StWait, StWrite, StDone} state_e;

  state_e state_q, state_d;

  logic [SYN_ARRAY_ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [PRE_NEUR_ADDR_WIDTH-1:0]       pre_q, pre_d;
  logic [POST_NEUR_WORD_ADDR_WIDTH-1:0] post_q, post_d;

  logic cs_q, cs_d;
  logic we_q, we_d;
  logic tref_q, tref_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic clear;
  logic advance;
  logic last_word;

  assign last_word = (pre_q == LastPre) && (post_q == LastPost);

  // Next-state and strobe decode
  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    advance = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start_update && bus.is_train) begin
          state_d = StRead;
          clear   = 1'b1;
        end
      end
      StRead:  state_d = StWait;
      StWait:  state_d = StWrite;
      StWrite: begin
        if (last_word) begin
          state_d = StDone;
        end else begin
          state_d = StRead;
          advance = 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outputs are registered from the next state so they line up with the state they describe.
    cs_d   = (state_d == StRead) || (state_d == StWrite);
    we_d   = (state_d == StWrite);
    tref_d = (state_d == StWrite);
    busy_d = (state_d == StRead) || (state_d == StWait) || (state_d == StWrite);
    done_d = (state_d == StDone);
  end

  // Word counters: addresses only move on WRITE->READ, so they hold through a word and after the sweep.
  always_comb begin
    addr_d = addr_q;
    pre_d  = pre_q;
    post_d = post_q;
    if (clear) begin
      addr_d = '0;
      pre_d  = '0;
      post_d = '0;
    end else if (advance) begin
      addr_d = addr_q + 1'b1;
      if (post_q == LastPost) begin
        post_d = '0;
        pre_d  = pre_q + 1'b1;
      end else begin
        post_d = post_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      pre_q   <= '0;
      post_q  <= '0;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      tref_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pre_q   <= pre_d;
      post_q  <= post_d;
      cs_q    <= cs_d;
      we_q    <= we_d;
      tref_q  <= tref_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Gradient strobes share the synaptic flops so the two arrays can never diverge.
  assign bus.ctrl_synarray_cs           = cs_q;
  assign bus.ctrl_synarray_we           = we_q;
  assign bus.ctrl_grad_array_cs         = cs_q;
  assign bus.ctrl_grad_array_we         = we_q;
  assign bus.ctrl_synarray_addr         = addr_q;
  assign bus.ctrl_pre_neuron_addr       = pre_q;
  assign bus.ctrl_post_neuron_word_addr = post_q;
  assign bus.ctrl_tref_event            = tref_q;
  assign bus.update_busy                = busy_q;
  assign bus.update_done                = done_q;

endmodule

// File: tb/tb_synapse_update_sequencer.sv
// Directed bench for synapse_update_sequencer with 3 pre neurons and 2 post words (6 words per sweep).
module tb_synapse_update_sequencer;

  localparam int unsigned IN_N  = 3;
  localparam int unsigned OUT_N = 8;
  localparam int unsigned PAR   = 4;
  localparam int unsigned PW    = OUT_N / PAR;
  localparam int unsigned WORDS = IN_N * PW;

  // Strobe vector order: {cs, we, grad_cs, grad_we, tref, busy, done}
  localparam logic [6:0] SIdle  = 7'b000_0000;
  localparam logic [6:0] SRead  = 7'b101_0010;
  localparam logic [6:0] SWait  = 7'b000_0010;
  localparam logic [6:0] SWrite = 7'b111_1110;
  localparam logic [6:0] SDone  = 7'b000_0001;

  logic clk;
  logic rst;

  int vectors;
  int miscompares;

  synapse_update_sequencer_if #(
    .SYN_ARRAY_ADDR_WIDTH      (4),
    .PRE_NEUR_ADDR_WIDTH       (2),
    .POST_NEUR_WORD_ADDR_WIDTH (1)
  ) bus ();

  synapse_update_sequencer #(
    .INPUT_NEURON              (IN_N),
    .OUTPUT_NEURON             (OUT_N),
    .POST_NEUR_PARALLEL        (PAR),
    .SYN_ARRAY_ADDR_WIDTH      (4),
    .PRE_NEUR_ADDR_WIDTH       (2),
    .POST_NEUR_WORD_ADDR_WIDTH (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] strobes();
    return {bus.ctrl_synarray_cs, bus.ctrl_synarray_we, bus.ctrl_grad_array_cs,
            bus.ctrl_grad_array_we, bus.ctrl_tref_event, bus.update_busy, bus.update_done};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [6:0] s, input int addr, input int pre,
                         input int post);
    chk({tag, " strobes"}, 32'(strobes()), 32'(s));
    chk({tag, " addr"}, 32'(bus.ctrl_synarray_addr), addr);
    chk({tag, " pre"}, 32'(bus.ctrl_pre_neuron_addr), pre);
    chk({tag, " post"}, 32'(bus.ctrl_post_neuron_word_addr), post);
  endtask

  // Full sweep starting now. poke>0: pulse START at that cycle, drop IS_TRAIN after it,
  // and pulse START again during DONE; none of that may disturb the sweep.
  task automatic run_sweep(input string tag, input int poke);
    bus.start_update = 1'b1;
    bus.is_train     = 1'b1;
    step();
    bus.start_update = 1'b0;
    for (int w = 0; w < int'(WORDS); w++) begin
      for (int p = 0; p < 3; p++) begin
        logic [6:0] s;
        s = (p == 0) ? SRead : (p == 1) ? SWait : SWrite;
        chk_all($sformatf("%s w%0d p%0d", tag, w, p), s, w, w / int'(PW), w % int'(PW));
        bus.start_update = ((w * 3 + p + 1) == poke);
        if (poke > 0 && (w * 3 + p + 1) > poke) bus.is_train = 1'b0;
        step();
      end
    end
    bus.start_update = (poke > 0);
    chk_all({tag, " done"}, SDone, WORDS - 1, IN_N - 1, PW - 1);
    step();
    bus.start_update = 1'b0;
    bus.is_train     = 1'b1;
    chk_all({tag, " idle"}, SIdle, WORDS - 1, IN_N - 1, PW - 1);
  endtask

  initial begin
    vectors          = 0;
    miscompares      = 0;
    rst              = 1'b1;
    bus.start_update = 1'b0;
    bus.is_train     = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state and quiet idle
    for (int i = 0; i < 5; i++) begin
      chk_all($sformatf("reset idle %0d", i), SIdle, 0, 0, 0);
      step();
    end

    // Two sweeps; the second START lands in the IDLE cycle right after DONE
    run_sweep("sweep1", 0);
    run_sweep("b2b", 0);

    // START without training mode
    bus.is_train     = 1'b0;
    bus.start_update = 1'b1;
    step();
    bus.start_update = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("no-train %0d", i), 32'(strobes()), 32'(SIdle));
      step();
    end

    // Repeated START mid-sweep, IS_TRAIN dropped mid-sweep, START during DONE
    run_sweep("poke", 7);
    step();
    chk("after poke idle", 32'(strobes()), 32'(SIdle));

    // Reset in WAIT of word 3 (cycle 11 after start)
    bus.is_train     = 1'b1;
    bus.start_update = 1'b1;
    step();
    bus.start_update = 1'b0;
    for (int i = 1; i < 11; i++) step();
    chk_all("pre-reset wait w3", SWait, 3, 1, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_all("reset mid-sweep", SIdle, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("abandoned %0d", i), 32'(strobes()), 32'(SIdle));
      step();
    end

    run_sweep("restart", 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
